// File: rtl/vram_pkg.sv
// Shared VRAM arbiter constants, state encoding and pointer helper.
package vram_pkg;

  localparam int LINE_W   = 640;
  localparam int ADDR_W   = 9;
  localparam int MAX_LINE = 479;
  localparam int TIMEOUT  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    OWN   = 2'd2,
    WRITE = 2'd3
  } state_t;

  function automatic int next_client(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Client-side and VRAM-side bundle of the VRAM arbiter; master drives requests, slave is the arbiter.
interface vram_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int LINE_W      = vram_pkg::LINE_W,
  parameter int ADDR_W      = vram_pkg::ADDR_W
);

  logic [NUM_CLIENTS-1:0]        req;
  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr;
  logic [NUM_CLIENTS*LINE_W-1:0] wr_line;
  logic [NUM_CLIENTS-1:0]        wr_done;
  logic [NUM_CLIENTS-1:0]        grant;
  logic [LINE_W-1:0]             rd_line;
  logic [ADDR_W-1:0]             vram_addr;
  logic [LINE_W-1:0]             vram_rd_data;
  logic                          vram_we;
  logic [LINE_W-1:0]             vram_wr_data;
  logic                          scan_hold;
  logic                          busy;
  logic                          addr_err;
  logic                          timeout_err;

  modport master (
    output req, req_addr, wr_line, wr_done, vram_rd_data, scan_hold,
    input  grant, rd_line, vram_addr, vram_we, vram_wr_data, busy, addr_err, timeout_err
  );

  modport slave (
    input  req, req_addr, wr_line, wr_done, vram_rd_data, scan_hold,
    output grant, rd_line, vram_addr, vram_we, vram_wr_data, busy, addr_err, timeout_err
  );

endinterface

// File: rtl/vram_arbiter_rr.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo NUM_CLIENTS.
module rr_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_CLIENTS-1:0] winner,
  output logic [IDX_W-1:0]       index,
  output logic                   valid
);

  int               cand_s;
  logic [IDX_W-1:0] cand_idx_s;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    cand_s     = 0;
    cand_idx_s = '0;
    index      = '0;
    valid      = 1'b0;
    winner     = '0;
    for (int off = NUM_CLIENTS - 1; off >= 0; off--) begin
      cand_s     = int'(ptr) + off;
      cand_s     = (cand_s >= NUM_CLIENTS) ? cand_s - NUM_CLIENTS : cand_s;
      cand_idx_s = IDX_W'(cand_s);
      index      = req[cand_idx_s] ? cand_idx_s : index;
      valid      = valid | req[cand_idx_s];
    end
    winner[index] = valid;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Read-modify-write VRAM arbiter: one client at a time reads a line, owns it, then writes it back.
// vram_addr is the VRAM's address register, so read data is valid during READ.
module vram_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int LINE_W      = vram_pkg::LINE_W,
  parameter int ADDR_W      = vram_pkg::ADDR_W,
  parameter int MAX_LINE    = vram_pkg::MAX_LINE,
  parameter int TIMEOUT     = vram_pkg::TIMEOUT
) (
  input logic           clk,
  input logic           rst_n,
  vram_arbiter_if.slave bus
);

  import vram_pkg::*;

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t                 state_r;
  logic [IDX_W-1:0]       ptr_r;
  logic [IDX_W-1:0]       owner_r;
  logic [NUM_CLIENTS-1:0] owner_oh_r;
  logic [NUM_CLIENTS-1:0] grant_r;
  logic [ADDR_W-1:0]      vram_addr_r;
  logic [TMO_W-1:0]       tmo_cnt_r;
  logic [LINE_W-1:0]      rd_line_r;
  logic [LINE_W-1:0]      wr_data_r;
  logic                   we_r;
  logic                   busy_r;
  logic                   addr_err_r;
  logic                   timeout_err_r;

  logic [NUM_CLIENTS-1:0] win_oh_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic                   win_valid_s;
  logic [ADDR_W-1:0]      win_addr_s;
  logic                   own_done_s;
  logic                   own_req_s;
  logic [LINE_W-1:0]      own_line_s;

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .req    (bus.req),
    .ptr    (ptr_r),
    .winner (win_oh_s),
    .index  (win_idx_s),
    .valid  (win_valid_s)
  );

  assign win_addr_s = bus.req_addr[win_idx_s*ADDR_W +: ADDR_W];
  assign own_done_s = |(bus.wr_done & owner_oh_r);
  assign own_req_s  = |(bus.req & owner_oh_r);
  assign own_line_s = bus.wr_line[owner_r*LINE_W +: LINE_W];

  // Transaction FSM with all outputs registered; error flags are one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      ptr_r         <= '0;
      owner_r       <= '0;
      owner_oh_r    <= '0;
      grant_r       <= '0;
      vram_addr_r   <= '0;
      tmo_cnt_r     <= '0;
      rd_line_r     <= '0;
      wr_data_r     <= '0;
      we_r          <= 1'b0;
      busy_r        <= 1'b0;
      addr_err_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      addr_err_r    <= 1'b0;
      timeout_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!bus.scan_hold && win_valid_s) begin
            if (int'(win_addr_s) > MAX_LINE) begin
              addr_err_r <= 1'b1;
              ptr_r      <= IDX_W'(next_client(int'(win_idx_s), NUM_CLIENTS));
            end else begin
              owner_r     <= win_idx_s;
              owner_oh_r  <= win_oh_s;
              vram_addr_r <= win_addr_s;
              busy_r      <= 1'b1;
              state_r     <= READ;
            end
          end
        end
        READ: begin
          rd_line_r <= bus.vram_rd_data;
          grant_r   <= owner_oh_r;
          tmo_cnt_r <= '0;
          state_r   <= OWN;
        end
        OWN: begin
          // A strobe on the cycle the request drops still counts as a completed write.
          if (own_done_s) begin
            wr_data_r <= own_line_s;
            we_r      <= 1'b1;
            grant_r   <= '0;
            state_r   <= WRITE;
          end else if (!own_req_s || (tmo_cnt_r == TMO_W'(TIMEOUT - 1))) begin
            timeout_err_r <= own_req_s;
            grant_r       <= '0;
            busy_r        <= 1'b0;
            ptr_r         <= IDX_W'(next_client(int'(owner_r), NUM_CLIENTS));
            state_r       <= IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        WRITE: begin
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          ptr_r   <= IDX_W'(next_client(int'(owner_r), NUM_CLIENTS));
          state_r <= IDLE;
        end
        default: begin
          grant_r <= '0;
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant        = grant_r;
  assign bus.rd_line      = rd_line_r;
  assign bus.vram_addr    = vram_addr_r;
  assign bus.vram_we      = we_r;
  assign bus.vram_wr_data = wr_data_r;
  assign bus.busy         = busy_r;
  assign bus.addr_err     = addr_err_r;
  assign bus.timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected grants/writes are queued at request time and
// popped when the DUT raises a grant or a VRAM write.
module tb_vram_arbiter;

  localparam int N  = 4;
  localparam int LW = 640;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vram_arbiter_if #(.NUM_CLIENTS(N), .LINE_W(LW), .ADDR_W(AW)) vif ();

  vram_arbiter #(
    .NUM_CLIENTS (N),
    .LINE_W      (LW),
    .ADDR_W      (AW),
    .MAX_LINE    (479),
    .TIMEOUT     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  typedef struct { int client; logic [LW-1:0] line; } gexp_t;
  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] data; } wexp_t;

  gexp_t gq[$];
  wexp_t wq[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int we_cnt = 0;
  int aerr_cnt = 0;
  int terr_cnt = 0;

  // Client behaviour: main thread owns want/quota/auto/delay, responder owns done_cnt/own_cnt.
  bit [N-1:0] want = '0;
  bit [N-1:0] auto_en = '0;
  int delay_v [N];
  int quota_end [N];
  int done_cnt [N];
  int own_cnt [N];

  logic [LW-1:0] wmem [0:511];
  bit            written [0:511];
  logic [LW-1:0] shadow [0:511];
  bit            shadow_w [0:511];

  function automatic logic [LW-1:0] pattern(input int a);
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = 32'hC0DE_0000 + 32'(a * 20 + k);
    return v;
  endfunction

  function automatic logic [LW-1:0] wdata(input int seed);
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = 32'hD00D_0000 ^ 32'(seed * 97 + k * 13);
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_line(input int a);
    return shadow_w[a] ? shadow[a] : pattern(a);
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // VRAM model: address already registered by the arbiter, data write on the clock edge.
  always_comb vif.vram_rd_data = written[vif.vram_addr] ? wmem[vif.vram_addr] : pattern(int'(vif.vram_addr));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vif.vram_we) begin
      wmem[vif.vram_addr]    <= vif.vram_wr_data;
      written[vif.vram_addr] <= 1'b1;
    end
  end

  always_comb begin
    vif.req = '0;
    for (int i = 0; i < N; i++) vif.req[i] = want[i] && (done_cnt[i] < quota_end[i]);
  end

  // Responder: strobe wr_done delay_v cycles into ownership; hitting the quota drops req that same cycle.
  initial begin
    vif.wr_done = '0;
    for (int i = 0; i < N; i++) begin done_cnt[i] = 0; own_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (vif.grant[i] && rst_n) begin
          vif.wr_done[i] = auto_en[i] && (own_cnt[i] == delay_v[i]);
          if (vif.wr_done[i]) done_cnt[i]++;
          own_cnt[i]++;
        end else begin
          vif.wr_done[i] = 1'b0;
          own_cnt[i]     = 0;
        end
      end
    end
  end

  // Monitor: pops the scoreboards on grant rise and on every VRAM write.
  initial begin
    bit [N-1:0] prev_grant;
    bit [N-1:0] oh;
    gexp_t g;
    wexp_t w;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("grant_onehot0", LW'($onehot0(vif.grant)), LW'(1));
        if (vif.vram_we) begin
          we_cnt++;
          check("we_while_busy", LW'(vif.busy), LW'(1));
          if (wq.size() == 0) check("we_unexpected", LW'(vif.vram_addr) | LW'(1 << AW), LW'(0));
          else begin
            w = wq.pop_front();
            check("we_addr", LW'(vif.vram_addr), LW'(w.addr));
            check("we_data", vif.vram_wr_data, w.data);
          end
        end
        if (vif.grant != '0 && prev_grant == '0) begin
          if (gq.size() == 0) check("grant_unexpected", LW'(vif.grant), LW'(0));
          else begin
            g  = gq.pop_front();
            oh = N'(1) << g.client;
            check("grant_who", LW'(vif.grant), LW'(oh));
            check("rd_line", vif.rd_line, g.line);
          end
        end
        if (vif.addr_err) aerr_cnt++;
        if (vif.timeout_err) terr_cnt++;
      end
      prev_grant = vif.grant;
    end
  end

  task automatic push_txn(input int c, input int a, input logic [LW-1:0] d, input bit writes);
    gq.push_back('{client: c, line: exp_line(a)});
    if (writes) begin
      wq.push_back('{addr: AW'(a), data: d});
      shadow[a]   = d;
      shadow_w[a] = 1'b1;
    end
  endtask

  task automatic request(input int c, input int a, input logic [LW-1:0] d, input int dly,
                         input int n, input bit auto_done);
    vif.req_addr[c*AW +: AW] = AW'(a);
    vif.wr_line[c*LW +: LW]  = d;
    delay_v[c]   = dly;
    auto_en[c]   = auto_done;
    quota_end[c] = done_cnt[c] + n;
    want[c]      = 1'b1;
  endtask

  // kind 0: grant[client], 1: timeout_err, 2: addr_err, 3: scoreboards drained and idle.
  task automatic wait_event(input int kind, input int client, input string tag, output int at);
    bit hit;
    hit = 1'b0;
    at  = -1000;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge clk);
      case (kind)
        0: hit = vif.grant[client];
        1: hit = vif.timeout_err;
        2: hit = vif.addr_err;
        default: hit = (gq.size() == 0) && (wq.size() == 0) && !vif.busy;
      endcase
    end
    if (hit) at = cyc;
    check(tag, LW'(hit), LW'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    want  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, g, t, r, x, base;
    vif.req_addr  = '0;
    vif.wr_line   = '0;
    vif.scan_hold = 1'b0;
    for (int i = 0; i < N; i++) begin delay_v[i] = 0; quota_end[i] = 0; end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_grant", LW'(vif.grant), LW'(0));
    check("rst_we", LW'(vif.vram_we), LW'(0));
    check("rst_busy", LW'(vif.busy), LW'(0));
    check("rst_errs", LW'({vif.addr_err, vif.timeout_err}), LW'(0));
    check("rst_vram_addr", LW'(vif.vram_addr), LW'(0));
    check("rst_rd_line", vif.rd_line, LW'(0));
    check("rst_wr_data", vif.vram_wr_data, LW'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single client, line 10, wr_done three cycles into ownership.
    @(negedge clk);
    request(0, 10, wdata(1), 3, 1, 1'b1);
    push_txn(0, 10, wdata(1), 1'b1);
    t0   = cyc;
    base = we_cnt;
    wait_event(0, 0, "A_grant_seen", g);
    check("A_grant_latency", LW'(g - t0), LW'(2));
    wait_event(3, 0, "A_drained", x);
    check("A_we_once", LW'(we_cnt - base), LW'(1));
    check("A_line10", wmem[10], wdata(1));
    want[0] = 1'b0;

    // All four held, each completes at once: order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) request(i, 100 + i, wdata(10 + i), 0, (i == 0) ? 2 : 1, 1'b1);
    for (int i = 0; i < N; i++) push_txn(i, 100 + i, wdata(10 + i), 1'b1);
    push_txn(0, 100, wdata(10), 1'b1);
    wait_event(3, 0, "B_drained", x);
    want = '0;

    // Client 2 out of range, client 3 served next.
    do_reset();
    base = aerr_cnt;
    request(2, 480, wdata(20), 0, 1, 1'b1);
    request(3, 20, wdata(21), 0, 1, 1'b1);
    push_txn(3, 20, wdata(21), 1'b1);
    wait_event(2, 0, "C_addr_err_seen", x);
    want[2] = 1'b0;
    wait_event(3, 0, "C_drained", x);
    check("C_addr_err_pulses", LW'(aerr_cnt - base), LW'(1));
    want = '0;

    // Client 1 never strobes: timeout 16 cycles after grant, then client 2.
    do_reset();
    base = terr_cnt;
    request(1, 30, wdata(30), 0, 1, 1'b0);
    request(2, 31, wdata(31), 0, 1, 1'b1);
    push_txn(1, 30, wdata(30), 1'b0);
    push_txn(2, 31, wdata(31), 1'b1);
    wait_event(0, 1, "D_grant_seen", g);
    wait_event(1, 0, "D_timeout_seen", t);
    want[1] = 1'b0;
    check("D_timeout_latency", LW'(t - g), LW'(16));
    wait_event(3, 0, "D_drained", x);
    check("D_timeout_pulses", LW'(terr_cnt - base), LW'(1));
    want = '0;

    // scan_hold blocks a start, then rising it mid-transaction does not abort.
    do_reset();
    vif.scan_hold = 1'b1;
    request(1, 40, wdata(40), 2, 1, 1'b1);
    push_txn(1, 40, wdata(40), 1'b1);
    repeat (6) @(negedge clk);
    check("E_hold_grant", LW'(vif.grant), LW'(0));
    check("E_hold_busy", LW'(vif.busy), LW'(0));
    vif.scan_hold = 1'b0;
    r = cyc;
    wait_event(0, 1, "E_grant_seen", g);
    check("E_release_latency", LW'((g - r) <= 2), LW'(1));
    vif.scan_hold = 1'b1;
    wait_event(3, 0, "E_drained", x);
    vif.scan_hold = 1'b0;
    want = '0;

    // Reset in OWN abandons the write and returns the pointer to 0.
    do_reset();
    request(1, 50, wdata(50), 0, 1, 1'b1);
    push_txn(1, 50, wdata(50), 1'b1);
    wait_event(3, 0, "F_first_drained", x);
    request(2, 51, wdata(51), 0, 1, 1'b0);
    push_txn(2, 51, wdata(51), 1'b0);
    wait_event(0, 2, "F_grant_seen", g);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("F_rst_grant", LW'(vif.grant), LW'(0));
    check("F_rst_we", LW'(vif.vram_we), LW'(0));
    want = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("F_idle_after_rst", LW'(vif.busy), LW'(0));
    for (int i = 0; i < N; i++) request(i, 60 + i, wdata(60 + i), 0, 1, 1'b1);
    for (int i = 0; i < N; i++) push_txn(i, 60 + i, wdata(60 + i), 1'b1);
    wait_event(3, 0, "F_drained", x);
    want = '0;

    check("end_grant_queue", LW'(gq.size()), LW'(0));
    check("end_write_queue", LW'(wq.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
